// File: rtl/mips_alu_hilo.sv
// HI/LO register unit for the execute stage: commits multiply/move-to results
// and computes divides with an iterative restoring divider while stalling.
typedef enum logic [4:0] {
    Add, Addu, Sub, Subu, Alu_And, Alu_Or, Alu_Xor, Alu_Nor, Slt, Sltu,
    Sll, Srl, Sra, Muls, Mulu, Divs, Divu, Mfhi, Mflo, Mthi, Mtlo
} Mips_Alu_Func_T;

module mips_alu_hilo #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              flush,
    input  Mips_Alu_Func_T    func,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic [DATA_W-1:0] res_lo,
    input  logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] reg_lo,
    output logic [DATA_W-1:0] reg_hi,
    output logic              stall
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem, quo, dvs;
    logic              q_neg, r_neg;

    logic              is_div, accept;
    logic [DATA_W:0]   rem_sh;
    logic              ge;
    logic [DATA_W-1:0] rem_nx, quo_nx;

    // Magnitude of a signed value; the most negative number keeps its bit pattern.
    function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] v);
        return (v < 0) ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
        return neg ? ('0 - v) : v;
    endfunction

    assign is_div = (func == Divs) || (func == Divu);
    assign accept = rst_n && valid && !flush && (state == IDLE);
    assign stall  = rst_n && ((state == BUSY) || (accept && is_div));

    // One restoring step: shift {rem, quo} left and subtract the divisor when it fits.
    assign rem_sh = {rem, quo[DATA_W-1]};
    assign ge     = (rem_sh >= {1'b0, dvs});
    assign rem_nx = ge ? (rem_sh[DATA_W-1:0] - dvs) : rem_sh[DATA_W-1:0];
    assign quo_nx = {quo[DATA_W-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            reg_lo <= '0;
            reg_hi <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (func)
                            Muls, Mulu: begin
                                reg_lo <= res_lo;
                                reg_hi <= res_hi;
                            end
                            Mtlo: reg_lo <= res_lo;
                            Mthi: reg_hi <= res_hi;
                            Divs, Divu: begin
                                if (data2 == '0) begin
                                    reg_lo <= '1;
                                    reg_hi <= data1;
                                    state  <= DONE;
                                end else begin
                                    cnt    <= CNT_W'(DATA_W);
                                    state  <= BUSY;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            reg_lo <= neg_if(q_neg, quo_nx);
                            reg_hi <= neg_if(r_neg, rem_nx);
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Divider working registers: reloaded every IDLE cycle, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            rem <= '0;
            if (func == Divs) begin
                quo   <= abs_val(data1);
                dvs   <= abs_val(data2);
                q_neg <= data1[DATA_W-1] ^ data2[DATA_W-1];
                r_neg <= data1[DATA_W-1];
            end else begin
                quo   <= data1;
                dvs   <= data2;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
            end
        end else if (state == BUSY) begin
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end
endmodule
